// File: rtl/core_types_pkg.sv
// core_types_pkg
//   Shared types and default configuration for the multi-way physical
//   register free list and its checkpoint ring.
//   - phys_reg_tag_t      : physical register tag
//   - free_list_ptr_t     : {wrap msb, array index} ring pointer
//   - checkpoint_column_t : checkpoint ring column
//   - ROB_index_t         : reorder-buffer index
//   - free_list_ckpt_t    : one checkpoint {valid, rob_idx, head}
//   - restore_action_t    : what a resolve does to the checkpoint ring
package core_types_pkg;

    localparam int unsigned FREE_LIST_NUM_PHYS_REGS = 64;
    localparam int unsigned FREE_LIST_NUM_ARCH_REGS = 32;
    localparam int unsigned FREE_LIST_DEQ_WIDTH     = 2;
    localparam int unsigned FREE_LIST_ENQ_WIDTH     = 2;
    localparam int unsigned FREE_LIST_CHECKPOINTS   = 4;
    localparam int unsigned FREE_LIST_ROB_IDX_W     = 6;

    localparam int unsigned PHYS_TAG_W = $clog2(FREE_LIST_NUM_PHYS_REGS);
    localparam int unsigned CKPT_COL_W = $clog2(FREE_LIST_CHECKPOINTS);

    typedef logic [PHYS_TAG_W-1:0]          phys_reg_tag_t;
    typedef logic [CKPT_COL_W-1:0]          checkpoint_column_t;
    typedef logic [FREE_LIST_ROB_IDX_W-1:0] ROB_index_t;

    typedef struct packed {
        logic          msb;
        phys_reg_tag_t idx;
    } free_list_ptr_t;

    typedef struct packed {
        logic           valid;
        ROB_index_t     rob_idx;
        free_list_ptr_t head;
    } free_list_ckpt_t;

    typedef enum logic [1:0] {
        RESTORE_NONE,
        RESTORE_RELEASE,
        RESTORE_REWIND
    } restore_action_t;

endpackage

// File: rtl/free_list_ckpt_ring.sv
// free_list_ckpt_ring
//   Ring of free-list head checkpoints used for branch recovery. Each
//   column holds {valid, rob_idx, head}. Saves go to the ring tail while
//   that column is free; a resolve either releases a column or, on a
//   mispredict, rewinds the ring so only the resolved column survives.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   save_valid        : save request (taken only when save_ready)
//   save_rob_idx      : ROB index tagged onto the checkpoint
//   save_head         : head pointer to store
//   save_column       : ring tail, the column a save writes
//   save_ready        : ring tail column is free
//   restore_valid     : resolve request
//   restore_mispredict: 1 = rewind, 0 = release only
//   restore_column    : column being resolved
//   restore_rob_idx   : expected ROB index
//   restore_success   : column valid and ROB index matches
//   restore_head      : head pointer stored in restore_column
module free_list_ckpt_ring
    import core_types_pkg::*;
#(
    parameter  int unsigned CHECKPOINTS = FREE_LIST_CHECKPOINTS,
    localparam int unsigned COL_W       = $clog2(CHECKPOINTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             save_valid,
    input  ROB_index_t       save_rob_idx,
    input  free_list_ptr_t   save_head,
    output logic [COL_W-1:0] save_column,
    output logic             save_ready,
    input  logic             restore_valid,
    input  logic             restore_mispredict,
    input  logic [COL_W-1:0] restore_column,
    input  ROB_index_t       restore_rob_idx,
    output logic             restore_success,
    output free_list_ptr_t   restore_head
);

    free_list_ckpt_t ckpt [CHECKPOINTS];
    logic [COL_W-1:0] ring_tail;
    restore_action_t  action;

    assign save_column  = ring_tail;
    assign save_ready   = ~ckpt[ring_tail].valid;
    assign restore_head = ckpt[restore_column].head;

    always_comb begin
        action          = RESTORE_NONE;
        restore_success = restore_valid
                        & ckpt[restore_column].valid
                        & (ckpt[restore_column].rob_idx == restore_rob_idx);
        if (restore_success) begin
            action = restore_mispredict ? RESTORE_REWIND : RESTORE_RELEASE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CHECKPOINTS; c++) begin
                ckpt[c] <= '0;
            end
            ring_tail <= '0;
        end else if (action == RESTORE_REWIND) begin
            // Younger checkpoints belong to the squashed path; the resolved
            // column stays valid until it is released explicitly.
            for (int unsigned c = 0; c < CHECKPOINTS; c++) begin
                if (COL_W'(c) != restore_column) begin
                    ckpt[c].valid <= 1'b0;
                end
            end
            ring_tail <= restore_column;
        end else begin
            // A releasable column is valid, so it can never be the free
            // tail column a same-cycle save writes.
            if (action == RESTORE_RELEASE) begin
                ckpt[restore_column].valid <= 1'b0;
            end
            if (save_valid && save_ready) begin
                ckpt[ring_tail] <= '{valid: 1'b1, rob_idx: save_rob_idx, head: save_head};
                ring_tail       <= ring_tail + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/phys_reg_free_list_mw.sv
// phys_reg_free_list_mw
//   Multi-way physical register free list for superscalar rename.
//   Hands out up to DEQ_WIDTH tags per cycle from head, accepts up to
//   ENQ_WIDTH freed tags per cycle at tail, and checkpoints the head for
//   branch recovery through free_list_ckpt_ring.
// Optional feature macro: FREE_LIST_DOUBLE_FREE_CHECK_EN
//   Adds an in-list bitmap that flags double frees, frees of tag 0 and
//   duplicate tags across lanes of one cycle.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   DUT_error         : registered one-cycle protocol-error flag
//   deq_count         : tags consumed this cycle
//   deq_tags          : tags at head+0..head+DEQ_WIDTH-1 (combinational)
//   deq_avail         : min(free_count, DEQ_WIDTH)
//   enq_valid/tags    : per-lane freed tags, lanes may be sparse
//   free_count        : registered occupancy; full/empty registered
//   save_*            : checkpoint save request / ring tail / ready
//   restore_*         : checkpoint resolve request / success
module phys_reg_free_list_mw
    import core_types_pkg::*;
#(
    parameter  int unsigned NUM_PHYS_REGS = FREE_LIST_NUM_PHYS_REGS,
    parameter  int unsigned NUM_ARCH_REGS = FREE_LIST_NUM_ARCH_REGS,
    parameter  int unsigned DEQ_WIDTH     = FREE_LIST_DEQ_WIDTH,
    parameter  int unsigned ENQ_WIDTH     = FREE_LIST_ENQ_WIDTH,
    parameter  int unsigned CHECKPOINTS   = FREE_LIST_CHECKPOINTS,
    parameter  int unsigned ROB_IDX_W     = FREE_LIST_ROB_IDX_W,
    localparam int unsigned TAG_W         = $clog2(NUM_PHYS_REGS),
    localparam int unsigned PTR_W         = TAG_W + 1,
    localparam int unsigned CNT_W         = $clog2(DEQ_WIDTH + 1),
    localparam int unsigned COL_W         = $clog2(CHECKPOINTS)
) (
    input  logic                            CLK,
    input  logic                            RST,
    output logic                            DUT_error,
    input  logic [CNT_W-1:0]                deq_count,
    output logic [DEQ_WIDTH-1:0][TAG_W-1:0] deq_tags,
    output logic [CNT_W-1:0]                deq_avail,
    input  logic [ENQ_WIDTH-1:0]            enq_valid,
    input  logic [ENQ_WIDTH-1:0][TAG_W-1:0] enq_tags,
    output logic [PTR_W-1:0]                free_count,
    output logic                            full,
    output logic                            empty,
    input  logic                            save_valid,
    input  logic [ROB_IDX_W-1:0]            save_rob_idx,
    output logic [COL_W-1:0]                save_column,
    output logic                            save_ready,
    input  logic                            restore_valid,
    input  logic                            restore_mispredict,
    input  logic [COL_W-1:0]                restore_column,
    input  logic [ROB_IDX_W-1:0]            restore_rob_idx,
    output logic                            restore_success
);

    localparam int unsigned SUM_W = PTR_W + 1;

    logic [TAG_W-1:0] entries [NUM_PHYS_REGS];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] next_head;
    logic [PTR_W-1:0] next_tail;
    logic [PTR_W-1:0] next_free_count;
    logic [PTR_W-1:0] save_head;
    logic [PTR_W-1:0] ckpt_head;
    logic [PTR_W-1:0] enq_pop;
    logic [ENQ_WIDTH-1:0][TAG_W-1:0] enq_addr;
    logic [CNT_W-1:0] deq_grant;

    logic rewind;
    logic err_enq;
    logic err_deq;
    logic err_save;
    logic err_dbl;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    always_comb begin
        if (free_count >= PTR_W'(DEQ_WIDTH)) begin
            deq_avail = CNT_W'(DEQ_WIDTH);
        end else begin
            deq_avail = free_count[CNT_W-1:0];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
            deq_tags[i] = entries[head[TAG_W-1:0] + TAG_W'(i)];
        end
    end

    // ------------------------------------------------------------------
    // Enqueue lane compaction: each valid lane lands at tail plus the
    // number of valid lanes below it.
    // ------------------------------------------------------------------
    always_comb begin
        enq_pop = '0;
        for (int unsigned l = 0; l < ENQ_WIDTH; l++) begin
            enq_addr[l] = tail[TAG_W-1:0] + enq_pop[TAG_W-1:0];
            enq_pop     = enq_pop + PTR_W'(enq_valid[l]);
        end
    end

    // ------------------------------------------------------------------
    // Pointer update and error detection
    // ------------------------------------------------------------------
    always_comb begin
        rewind          = restore_valid & restore_mispredict & restore_success;
        deq_grant       = (deq_count > deq_avail) ? deq_avail : deq_count;
        // A checkpoint taken alongside a dequeue keeps the branch's own
        // allocation, so it stores the post-dequeue head.
        save_head       = head + PTR_W'(deq_grant);
        next_head       = rewind ? ckpt_head : save_head;
        next_tail       = tail + enq_pop;
        next_free_count = next_tail - next_head;

        err_enq  = (SUM_W'(free_count) + SUM_W'(enq_pop)) > SUM_W'(NUM_PHYS_REGS);
        err_deq  = ~rewind & (deq_count > deq_avail);
        err_save = ~rewind & save_valid & ~save_ready;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
                entries[i] <= TAG_W'(i);
            end
            head       <= PTR_W'(NUM_ARCH_REGS);
            tail       <= {1'b1, {TAG_W{1'b0}}};
            free_count <= PTR_W'(NUM_PHYS_REGS - NUM_ARCH_REGS);
            full       <= 1'b0;
            empty      <= 1'b0;
            DUT_error  <= 1'b0;
        end else begin
            // Frees are written even on overflow or during a rewind.
            for (int unsigned l = 0; l < ENQ_WIDTH; l++) begin
                if (enq_valid[l]) begin
                    entries[enq_addr[l]] <= enq_tags[l];
                end
            end
            head       <= next_head;
            tail       <= next_tail;
            free_count <= next_free_count;
            full       <= (next_free_count == PTR_W'(NUM_PHYS_REGS));
            empty      <= (next_free_count == '0);
            DUT_error  <= err_enq | err_deq | err_save | err_dbl;
        end
    end

    // ------------------------------------------------------------------
    // Checkpoint ring
    // ------------------------------------------------------------------
    free_list_ckpt_ring #(
        .CHECKPOINTS (CHECKPOINTS)
    ) u_ckpt_ring (
        .clk                (CLK),
        .rst                (RST),
        .save_valid         (save_valid),
        .save_rob_idx       (save_rob_idx),
        .save_head          (save_head),
        .save_column        (save_column),
        .save_ready         (save_ready),
        .restore_valid      (restore_valid),
        .restore_mispredict (restore_mispredict),
        .restore_column     (restore_column),
        .restore_rob_idx    (restore_rob_idx),
        .restore_success    (restore_success),
        .restore_head       (ckpt_head)
    );

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    // ------------------------------------------------------------------
    // In-list bitmap: one bit per tag currently between head and tail.
    // ------------------------------------------------------------------
    logic [NUM_PHYS_REGS-1:0] in_list;
    logic [NUM_PHYS_REGS-1:0] next_in_list;
    logic [PTR_W-1:0]         rewind_span;
    logic [TAG_W-1:0]         rewind_off;

    always_comb begin
        next_in_list = in_list;
        err_dbl      = 1'b0;
        rewind_span  = head - ckpt_head;
        rewind_off   = '0;
        if (rewind) begin
            // Tags handed out since the checkpoint return to the list.
            for (int unsigned j = 0; j < NUM_PHYS_REGS; j++) begin
                rewind_off = TAG_W'(j) - ckpt_head[TAG_W-1:0];
                if (PTR_W'(rewind_off) < rewind_span) begin
                    next_in_list[entries[j]] = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
                if (CNT_W'(i) < deq_grant) begin
                    next_in_list[deq_tags[i]] = 1'b0;
                end
            end
        end
        for (int unsigned l = 0; l < ENQ_WIDTH; l++) begin
            if (enq_valid[l]) begin
                if (in_list[enq_tags[l]] || (enq_tags[l] == '0)) begin
                    err_dbl = 1'b1;
                end
                for (int unsigned m = 0; m < l; m++) begin
                    if (enq_valid[m] && (enq_tags[m] == enq_tags[l])) begin
                        err_dbl = 1'b1;
                    end
                end
                next_in_list[enq_tags[l]] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
                in_list[i] <= (i >= NUM_ARCH_REGS);
            end
        end else begin
            in_list <= next_in_list;
        end
    end
`else
    assign err_dbl = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list_mw.sv
module tb_phys_reg_free_list_mw;

    localparam int N    = 64;
    localparam int ARCH = 32;
    localparam int D    = 2;
    localparam int E    = 2;
    localparam int C    = 4;

    logic               CLK = 1'b0;
    logic               RST;
    logic               DUT_error;
    logic [1:0]         deq_count;
    logic [D-1:0][5:0]  deq_tags;
    logic [1:0]         deq_avail;
    logic [E-1:0]       enq_valid;
    logic [E-1:0][5:0]  enq_tags;
    logic [6:0]         free_count;
    logic               full;
    logic               empty;
    logic               save_valid;
    logic [5:0]         save_rob_idx;
    logic [1:0]         save_column;
    logic               save_ready;
    logic               restore_valid;
    logic               restore_mispredict;
    logic [1:0]         restore_column;
    logic [5:0]         restore_rob_idx;
    logic               restore_success;

    phys_reg_free_list_mw #(
        .NUM_PHYS_REGS (N),
        .NUM_ARCH_REGS (ARCH),
        .DEQ_WIDTH     (D),
        .ENQ_WIDTH     (E),
        .CHECKPOINTS   (C),
        .ROB_IDX_W     (6)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .DUT_error          (DUT_error),
        .deq_count          (deq_count),
        .deq_tags           (deq_tags),
        .deq_avail          (deq_avail),
        .enq_valid          (enq_valid),
        .enq_tags           (enq_tags),
        .free_count         (free_count),
        .full               (full),
        .empty              (empty),
        .save_valid         (save_valid),
        .save_rob_idx       (save_rob_idx),
        .save_column        (save_column),
        .save_ready         (save_ready),
        .restore_valid      (restore_valid),
        .restore_mispredict (restore_mispredict),
        .restore_column     (restore_column),
        .restore_rob_idx    (restore_rob_idx),
        .restore_success    (restore_success)
    );

    always #5 CLK = ~CLK;

    // Expected DUT outputs for one cycle.
    typedef struct packed {
        logic [D-1:0][5:0] tags;
        logic [1:0]        avail;
        logic [6:0]        fc;
        logic              full;
        logic              empty;
        logic              err;
        logic              sready;
        logic [1:0]        scol;
        logic              rsucc;
    } exp_t;

    typedef struct packed {
        int tag;
        int pos;
    } pool_t;

    exp_t  expq[$];
    pool_t pool[$];   // allocated tags that stimulus may free later

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: free list as an array addressed by unbounded
    // absolute positions; occupancy is simply tl - hd.
    int mem_m [N];
    int hd;
    int tl;
    bit ck_v   [C];
    int ck_rob [C];
    int ck_hd  [C];
    int rt;
    bit err_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mem_m[i] = i;
        hd = ARCH;
        tl = N;
        for (int c = 0; c < C; c++) begin
            ck_v[c]   = 1'b0;
            ck_rob[c] = 0;
            ck_hd[c]  = 0;
        end
        rt    = 0;
        err_m = 1'b0;
        pool.delete();
    endtask

    // Drive one cycle of inputs, queue the expected outputs for this
    // cycle, advance the model, then move to just after the next edge.
    task automatic step(input bit rst, input int dc, input logic [E-1:0] ev,
                        input logic [E-1:0][5:0] et, input bit sv, input int srob,
                        input bit rv, input bit rm, input int rcol, input int rrob);
        exp_t e;
        int   fc, av, pop, grant, k;
        bit   succ, mis, ready, errn;

        RST                = rst;
        deq_count          = 2'(dc);
        enq_valid          = ev;
        enq_tags           = et;
        save_valid         = sv;
        save_rob_idx       = 6'(srob);
        restore_valid      = rv;
        restore_mispredict = rm;
        restore_column     = 2'(rcol);
        restore_rob_idx    = 6'(rrob);

        fc   = tl - hd;
        av   = (fc < D) ? fc : D;
        succ = rv && ck_v[rcol] && (ck_rob[rcol] == rrob);
        for (int i = 0; i < D; i++) e.tags[i] = 6'(mem_m[(hd + i) % N]);
        e.avail  = 2'(av);
        e.fc     = 7'(fc);
        e.full   = (fc == N);
        e.empty  = (fc == 0);
        e.err    = err_m;
        e.sready = !ck_v[rt];
        e.scol   = 2'(rt);
        e.rsucc  = succ;
        expq.push_back(e);

        if (rst) begin
            model_reset();
        end else begin
            mis   = succ && rm;
            ready = !ck_v[rt];
            errn  = 1'b0;
            pop   = 0;
            for (int l = 0; l < E; l++) if (ev[l]) pop++;
            if (fc + pop > N) errn = 1'b1;
            grant = (dc > av) ? av : dc;
            if (!mis && dc > av) errn = 1'b1;
            if (!mis && sv && !ready) errn = 1'b1;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
            for (int l = 0; l < E; l++) begin
                if (ev[l]) begin
                    if (et[l] == 6'd0) errn = 1'b1;
                    for (int p = hd; p < tl; p++) if (mem_m[p % N] == int'(et[l])) errn = 1'b1;
                    for (int m = 0; m < l; m++) if (ev[m] && et[m] == et[l]) errn = 1'b1;
                end
            end
`endif
            if (mis) begin
                for (int j = pool.size() - 1; j >= 0; j--)
                    if (pool[j].pos >= ck_hd[rcol]) pool.delete(j);
                hd = ck_hd[rcol];
                for (int c = 0; c < C; c++) if (c != rcol) ck_v[c] = 1'b0;
                rt = rcol;
            end else begin
                for (int i = 0; i < grant; i++) pool.push_back('{tag: mem_m[(hd + i) % N], pos: hd + i});
                if (succ) ck_v[rcol] = 1'b0;
                if (sv && ready) begin
                    ck_v[rt]   = 1'b1;
                    ck_rob[rt] = srob;
                    ck_hd[rt]  = hd + grant;
                    rt         = (rt + 1) % C;
                end
                hd = hd + grant;
            end
            k = 0;
            for (int l = 0; l < E; l++) begin
                if (ev[l]) begin
                    mem_m[(tl + k) % N] = int'(et[l]);
                    k++;
                end
            end
            tl    = tl + pop;
            err_m = errn;
        end

        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int dc);
        step(1'b0, dc, '0, '0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        step(1'b1, 0, '0, '0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic save(input int srob, input int dc);
        step(1'b0, dc, '0, '0, 1'b1, srob, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic resolve(input bit rm, input int rcol, input int rrob);
        step(1'b0, 0, '0, '0, 1'b0, 0, 1'b1, rm, rcol, rrob);
    endtask

    task automatic free_one(input int lane, input int tag);
        logic [E-1:0]      ev;
        logic [E-1:0][5:0] et;
        ev       = '0;
        et       = '0;
        ev[lane] = 1'b1;
        et[lane] = 6'(tag);
        step(1'b0, 0, ev, et, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic rand_cycle();
        logic [E-1:0]      ev;
        logic [E-1:0][5:0] et;
        int cand[$];
        int minhd, pick, rcol, rrob;
        bit rst;

        minhd = hd;
        for (int c = 0; c < C; c++) if (ck_v[c] && ck_hd[c] < minhd) minhd = ck_hd[c];
        for (int l = 0; l < E; l++) begin
            ev[l] = 1'b0;
            et[l] = 6'($urandom_range(63, 0));
            if ($urandom_range(1, 0) == 1) begin
                cand.delete();
                for (int j = 0; j < pool.size(); j++) if (pool[j].pos < minhd) cand.push_back(j);
                if (cand.size() > 0) begin
                    pick  = cand[$urandom_range(cand.size() - 1, 0)];
                    ev[l] = 1'b1;
                    et[l] = 6'(pool[pick].tag);
                    pool.delete(pick);
                end
            end
        end
        rcol = $urandom_range(C - 1, 0);
        rrob = ($urandom_range(1, 0) == 1) ? ck_rob[rcol] : int'($urandom_range(63, 0));
        rst  = ($urandom_range(299, 0) == 0);
        step(rst, $urandom_range(D, 0), ev, et,
             $urandom_range(3, 0) == 0, $urandom_range(63, 0),
             $urandom_range(3, 0) == 0, $urandom_range(2, 0) == 0, rcol, rrob);
    endtask

    // Monitor: compares one queued expectation per cycle at the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("deq_tags0",       32'(deq_tags[0]),    32'(e.tags[0]));
                chk("deq_tags1",       32'(deq_tags[1]),    32'(e.tags[1]));
                chk("deq_avail",       32'(deq_avail),      32'(e.avail));
                chk("free_count",      32'(free_count),     32'(e.fc));
                chk("full",            32'(full),           32'(e.full));
                chk("empty",           32'(empty),          32'(e.empty));
                chk("DUT_error",       32'(DUT_error),      32'(e.err));
                chk("save_ready",      32'(save_ready),     32'(e.sready));
                chk("save_column",     32'(save_column),    32'(e.scol));
                chk("restore_success", 32'(restore_success), 32'(e.rsucc));
            end
        end
    end

    initial begin
        int waited;
        RST = 1'b1; deq_count = '0; enq_valid = '0; enq_tags = '0;
        save_valid = 1'b0; save_rob_idx = '0; restore_valid = 1'b0;
        restore_mispredict = 1'b0; restore_column = '0; restore_rob_idx = '0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        // Reset state, then drain the list to empty.
        idle(0);
        repeat (16) idle(2);
        idle(0);

        // Sparse free on lane 1 into an empty list, then over-request.
        free_one(1, 5);
        idle(0);
        idle(2);
        idle(0);

        // Checkpoint, allocate past it, rewind.
        do_reset();
        idle(2);
        save(7, 0);
        idle(2);
        idle(2);
        resolve(1'b1, 0, 7);
        idle(0);
        resolve(1'b0, 0, 7);

        // Fill the ring, overflow it, mismatched then matching release.
        save(1, 1);
        save(2, 0);
        save(3, 2);
        save(4, 0);
        save(5, 0);
        idle(0);
        resolve(1'b0, 0, 9);
        idle(0);
        resolve(1'b0, 0, 1);
        idle(0);

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
        do_reset();
        free_one(0, 40);
        idle(0);
        free_one(1, 0);
        idle(0);
`endif

        // Randomised traffic against the model.
        do_reset();
        repeat (1500) rand_cycle();
        idle(0);

        waited = 0;
        while (expq.size() > 0 && waited < 5) begin
            @(posedge CLK);
            waited++;
        end
        #6;
        if (expq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: actual %0d pending required 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list_mw.md
Name: phys_reg_free_list_mw

Overview:
- Multi-way successor to the single-port physical register free list, for a superscalar dispatch unit.
- Supplies up to DEQ_WIDTH free physical register tags per cycle to rename.
- Accepts up to ENQ_WIDTH freed tags per cycle from retire.
- Keeps a parametrised ring of head-pointer checkpoints, each tagged with a ROB index, for branch recovery.
- Instantiated as system -> core -> dispatch_unit -> phys_reg_free_list_mw.

Parameters:
- NUM_PHYS_REGS, 64, total physical regs; power of 2; also the array depth.
- NUM_ARCH_REGS, 32, architectural regs; the initial free count is NUM_PHYS_REGS-NUM_ARCH_REGS.
- DEQ_WIDTH, 2, maximum allocations per cycle (1..4).
- ENQ_WIDTH, 2, maximum frees per cycle (1..4).
- CHECKPOINTS, 4, checkpoint ring entries; power of 2.
- ROB_IDX_W, 6, ROB index width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- DUT_error  out  1  registered protocol-error flag.
- deq_count  in  clog2(DEQ_WIDTH+1)  number of tags consumed this cycle.
- deq_tags  out  DEQ_WIDTH x log2(NUM_PHYS_REGS)  tags at head+0..head+DEQ_WIDTH-1; combinational read.
- deq_avail  out  clog2(DEQ_WIDTH+1)  min(free_count, DEQ_WIDTH).
- enq_valid  in  ENQ_WIDTH  per-lane free valid; lanes may be sparse.
- enq_tags  in  ENQ_WIDTH x log2(NUM_PHYS_REGS)  tags being freed.
- free_count  out  log2(NUM_PHYS_REGS)+1  registered occupancy.
- full, empty  out  1  registered; full = free_count==NUM_PHYS_REGS, empty = free_count==0.
- save_valid  in  1  request a checkpoint save.
- save_rob_idx  in  ROB_IDX_W  ROB index stored with the checkpoint.
- save_column  out  log2(CHECKPOINTS)  ring tail; the column a save this cycle writes.
- save_ready  out  1  tail column is not valid.
- restore_valid  in  1  resolve a checkpoint.
- restore_mispredict  in  1  1 = rewind head; 0 = release the checkpoint only.
- restore_column  in  log2(CHECKPOINTS)  column to resolve.
- restore_rob_idx  in  ROB_IDX_W  expected ROB index.
- restore_success  out  1  combinational; column valid and its ROB index matches.

Behaviour:
- Storage and pointers:
  - Array of NUM_PHYS_REGS tags.
  - head and tail are (log2(NUM_PHYS_REGS)+1)-bit pointers; the extra msb distinguishes full from empty.
  - All pointer arithmetic is modulo 2^(log2(NUM_PHYS_REGS)+1).
- Reset (RST high at a CLK edge):
  - entry[i]=i for every i.
  - head=NUM_ARCH_REGS with msb 0; tail=0 with msb 1.
  - free_count=NUM_PHYS_REGS-NUM_ARCH_REGS; full=0; empty=0.
  - All checkpoints invalid; ring tail=0; DUT_error=0.
  - Reset asserted mid-operation discards any same-cycle deq, enq, save or restore.
- Enqueue:
  - Valid lanes are compacted in ascending lane order and written at tail, tail+1, ...
  - tail advances by popcount(enq_valid).
  - Enqueue is always applied, including in a mispredict-restore cycle.
  - If free_count+popcount exceeds NUM_PHYS_REGS: DUT_error=1 next cycle, and the write is still performed.
- Dequeue:
  - head advances by deq_count.
  - deq_count>deq_avail: DUT_error=1 next cycle, and head advances only by deq_avail.
  - A tag enqueued in cycle N is first visible on deq_tags in cycle N+1. There is no same-cycle bypass.
- Priority when events coincide: mispredict restore > save > dequeue.
  - A successful mispredict restore ignores any same-cycle save and dequeue.
  - A save with a same-cycle dequeue: the checkpoint stores the post-dequeue head, so the branch's own allocation survives a restore.
- Save:
  - Only when save_ready=1.
  - Writes {valid=1, rob_idx, head} into the tail column; the ring tail increments and wraps at CHECKPOINTS.
  - save_valid while save_ready=0: save is dropped and DUT_error=1 next cycle.
- Restore with restore_mispredict=0:
  - On a match, clears the column's valid bit and sets restore_success=1.
  - It may coincide with a save or dequeue.
- Restore with restore_mispredict=1:
  - On a match, head is loaded from the checkpoint and the ring tail is set to restore_column.
  - Every column other than restore_column is invalidated; restore_column itself stays valid.
  - On a mismatch, restore_success=0 and no state changes.
- free_count and full/empty are computed from next_head/next_tail and registered, so they are correct at the start of each cycle.

Optional Feature:
- Macro: FREE_LIST_DOUBLE_FREE_CHECK_EN.
- When defined:
  - An NUM_PHYS_REGS-bit in-list bitmap is maintained.
  - Set on enqueue; cleared on dequeue.
  - Reset value: bits NUM_ARCH_REGS..NUM_PHYS_REGS-1 set.
  - On a mispredict restore, the bits for entries between the checkpoint head and the old head are set again.
  - DUT_error=1 next cycle for: an enqueue of a tag whose bit is already set, an enqueue of tag 0, or two lanes carrying the same tag in one cycle.
- When undefined: no bitmap, and none of these checks exist.

Decomposition:
- core_types_pkg holds:
  - phys_reg_tag_t, free_list_ptr_t (packed msb/index), checkpoint_column_t, ROB_index_t.
  - The typedef for the free_list_ckpt_t struct.
  - The FREE_LIST_DEQ_WIDTH and FREE_LIST_ENQ_WIDTH constants.
- One sub-module: free_list_ckpt_ring, which owns the checkpoint array, tail, save_ready, VTM match and invalidation.
- The top module keeps the array, pointers, counts, error logic and the optional bitmap.

Test Plan (defaults):
- Reset release, deq_count=0 -> deq_tags={32,33}, free_count=32, deq_avail=2, empty=0, full=0.
- deq_count=2 for 16 cycles -> tags 32..63 issued in order; free_count=0 and empty=1 the cycle after; deq_avail=0.
- From empty, enq_valid=2'b10 with enq_tags[1]=5 -> next cycle deq_tags[0]=5, free_count=1, deq_avail=1. Then deq_count=2 -> DUT_error=1, head advances by 1.
- Save at head=34 with rob_idx=7 -> save_column=0. Then allocate 4 tags. Then mispredict restore on column 0 with rob_idx 7 -> restore_success=1, deq_tags[0]=34, ring tail=0.
- Fill all 4 checkpoints -> save_ready=0. A 5th save -> dropped, DUT_error=1. A non-mispredict restore of column 0 with rob_idx 9 (mismatch) -> restore_success=0, column stays valid.
- With FREE_LIST_DOUBLE_FREE_CHECK_EN: enqueue tag 40 while it is still in the list -> DUT_error=1. Enqueue tag 0 -> DUT_error=1.
